// File: rtl/stall_ctrl_pkg.sv
// Shared encodings for the hazard/stall unit: Tuse/Tnew codes, HI/LO latencies
// and the multiply/divide timer state.
package stall_ctrl_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A source register hazards when a later stage will write it but the value
    // is not forwardable before the D instruction needs it.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (e_wa == src) && (e_tnew > tuse);
        m_hit = (m_wa == src) && (m_tnew > tuse);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Signal bundle between the pipeline and the stall controller; md_state is a
// debug view of the HI/LO timer.
interface stall_ctrl_if;
    import stall_ctrl_pkg::*;

    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_rs_tuse;
    logic [1:0]  d_rt_tuse;
    logic        d_is_md;
    logic [4:0]  e_wa;
    logic [1:0]  e_tnew;
    logic [4:0]  m_wa;
    logic [1:0]  m_tnew;
    logic        e_md_start;
    logic        e_md_op;
    logic        pc_en;
    logic        d_en;
    logic        e_flush;
    logic        md_busy;
    logic [31:0] stall_count;
    md_state_t   md_state;

    // Purely combinational request/response: no valid/ready, every cycle's
    // inputs produce that cycle's enables; md_busy/stall_count are registered.
    modport master (
        output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
        output e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_op,
        input  pc_en, d_en, e_flush, md_busy, stall_count, md_state
    );

    modport slave (
        input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_is_md,
        input  e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_op,
        output pc_en, d_en, e_flush, md_busy, stall_count, md_state
    );

endinterface

// File: rtl/stall_ctrl_md_timer.sv
// HI/LO busy timer: counts the fixed mult/div latency after a launch from E.
module md_timer
    import stall_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      op,
    output logic      busy,
    output md_state_t state
);

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while already busy is dropped; the hazard logic stalls it anyway.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = op ? DIV_CYCLES : MULT_CYCLES;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = MD_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign busy  = (state_q == MD_BUSY);
    assign state = state_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: register/HI-LO hazard detection, stall enables
// and a saturating count of stalled cycles.
module stall_ctrl
    import stall_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    stall_ctrl_if.slave  bus
);

    logic        rs_hazard;
    logic        rt_hazard;
    logic        md_hazard;
    logic        stall;
    logic        md_busy;
    md_state_t   md_state;
    logic [31:0] stall_count_q;

    md_timer u_md_timer (
        .clk   (clk),
        .rst   (reset),
        .start (bus.e_md_start),
        .op    (bus.e_md_op),
        .busy  (md_busy),
        .state (md_state)
    );

    assign rs_hazard = reg_hazard(bus.d_rs, bus.d_rs_tuse, bus.e_wa, bus.e_tnew,
                                  bus.m_wa, bus.m_tnew);
    assign rt_hazard = reg_hazard(bus.d_rt, bus.d_rt_tuse, bus.e_wa, bus.e_tnew,
                                  bus.m_wa, bus.m_tnew);
    // The launching cycle counts as busy because HI/LO are not yet updated.
    assign md_hazard = bus.d_is_md && (md_busy || bus.e_md_start);
    assign stall     = rs_hazard || rt_hazard || md_hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign bus.pc_en       = !stall;
    assign bus.d_en        = !stall;
    assign bus.e_flush     = stall;
    assign bus.md_busy     = md_busy;
    assign bus.stall_count = stall_count_q;
    assign bus.md_state    = md_state;

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset; clears all state immediately when asserted.
REQ-003 d_rs  in  5  rs register number of the instruction in D.
REQ-004 d_rt  in  5  rt register number of the instruction in D.
REQ-005 d_rs_tuse  in  2  cycles until D instr needs rs (0, 1, 2); 3 = rs not read.
REQ-006 d_rt_tuse  in  2  same encoding for rt.
REQ-007 d_is_md  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-008 e_wa  in  5  destination register of the instr in E; 0 = none.
REQ-009 e_tnew  in  2  cycles until the E result is forwardable.
REQ-010 m_wa  in  5  destination register of the instr in M; 0 = none.
REQ-011 m_tnew  in  2  cycles until the M result is forwardable.
REQ-012 e_md_start  in  1  E instr launches a mult/div this cycle.
REQ-013 e_md_op  in  1  0 = mult/multu, 1 = div/divu; valid with e_md_start.
REQ-014 pc_en  out  1  PC write enable.
REQ-015 d_en  out  1  enable of the F/D pipeline register.
REQ-016 e_flush  out  1  loads a bubble (instr = 0) into the D/E register.
REQ-017 md_busy  out  1  registered; HI/LO unit is mid-operation.
REQ-018 stall_count  out  32  registered count of stalled cycles since reset.

Function
REQ-019 rs hazard: d_rs != 0, d_rs_tuse != 3, and (e_wa == d_rs with e_tnew > d_rs_tuse, or m_wa == d_rs with m_tnew > d_rs_tuse).
REQ-020 rt hazard: same rule as REQ-019, applied to d_rt / d_rt_tuse.
REQ-021 md hazard: d_is_md and (md_busy or e_md_start).
REQ-022 stall = rs hazard or rt hazard or md hazard; combinational, same cycle.
REQ-023 pc_en = d_en = not stall; e_flush = stall.
REQ-024 Timer FSM has two states: IDLE and BUSY.
REQ-025 IDLE with e_md_start: go to BUSY and load cnt = 5 (e_md_op = 0) or 10 (e_md_op = 1).
REQ-026 BUSY: cnt decrements each cycle; when cnt == 1, next state is IDLE and cnt becomes 0.
REQ-027 md_busy = (state == BUSY); a mult asserts it for exactly 5 cycles, a div for exactly 10, starting the cycle after e_md_start.
REQ-028 e_md_start while BUSY is ignored; it cannot occur legally because REQ-021 stalls it.
REQ-029 stall_count increments by 1 on each clock edge where stall = 1, and saturates at 0xFFFFFFFF.
REQ-030 Simultaneous hazards produce one stall cycle, not separate stalls per hazard.

Reset
REQ-031 Reset forces state IDLE, cnt 0, md_busy 0, stall_count 0, asynchronously.
REQ-032 Reset during BUSY aborts the operation; md_busy is 0 in the first cycle after reset deasserts.
REQ-033 While in reset, outputs are driven combinationally from inputs with md_busy = 0.

Structure
REQ-034 A shared package holds: the Tuse/Tnew encodings, including the value TUSE_NONE = 3; the constants MULT_CYCLES = 5 and DIV_CYCLES = 10; and the timer state enum.
REQ-035 The timer (REQ-024 to REQ-028) is a separate sub-module, md_timer; hazard logic and stall_count stay at the top level.

Verification
REQ-036 Load-use: d_rs = 8, d_rs_tuse = 1, e_wa = 8, e_tnew = 2 -> stall = 1, pc_en = 0, e_flush = 1; with e_tnew = 1 instead -> no stall.
REQ-037 $0 guard: d_rs = 0, e_wa = 0, e_tnew = 2, d_rs_tuse = 0 -> no stall.
REQ-038 Mult then mfhi: e_md_start = 1, e_md_op = 0, with d_is_md = 1 held -> stall for 6 cycles (the start cycle plus 5 busy cycles), then released; stall_count = 6.
REQ-039 Div busy: e_md_start = 1, e_md_op = 1 -> md_busy high for exactly 10 cycles; a non-md D instr is never stalled during this window.
REQ-040 Reset mid-div: assert reset at busy cycle 4 -> md_busy = 0 and stall_count = 0 immediately; the next e_md_start restarts a full count.
REQ-041 Saturation: preload stall_count near 0xFFFFFFFF (force), hold stall = 1 -> count holds at 0xFFFFFFFF.
